// File: rtl/instr_fetch_sequencer.sv
// Fetch/execute sequencer for the CPUSystem datapath: one-hot timing bus,
// two-cycle IR fetch with PC increments, execute hand-off, halt and timeout.
module instr_fetch_sequencer #(
  parameter int          T_W       = 8,
  parameter int          CNT_W     = 16,
  parameter logic [1:0]  PC_SEL    = 2'b00,
  parameter logic [3:0]  PC_REGSEL = 4'b0111
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             run,
  input  logic             stall,
  input  logic             exec_done,
  input  logic             halt_req,
  output logic [T_W-1:0]   T,
  output logic             Mem_CS,
  output logic             Mem_WR,
  output logic             IR_Enable,
  output logic             IR_LH,
  output logic [1:0]       IR_Funsel,
  output logic [1:0]       ARF_OutDSel,
  output logic [3:0]       ARF_RegSel,
  output logic [1:0]       ARF_FunSel,
  output logic             opcode_valid,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_L = 3'd1,
    FETCH_H = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [T_W-1:0] T_ZERO  = '0;
  localparam logic [T_W-1:0] T_FIRST = {{(T_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   halt_pending;
  logic   fetching;
  logic   fetch_active;

  // Halt requests are latched so that one raised mid-instruction is honoured
  // at the next exec_done boundary; HALT itself is left only through Reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      T            <= T_ZERO;
      instr_count  <= '0;
      timeout_err  <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      if (halt_req && state != HALT)
        halt_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (halt_req || halt_pending) begin
            state <= HALT;
            T     <= T_ZERO;
          end else if (run) begin
            state <= FETCH_L;
            T     <= T_FIRST;
          end
        end
        FETCH_L: begin
          if (!stall) begin
            state <= FETCH_H;
            T     <= T_FIRST << 1;
          end
        end
        FETCH_H: begin
          if (!stall) begin
            state <= EXEC;
            T     <= T_FIRST << 2;
          end
        end
        EXEC: begin
          if (exec_done) begin
            instr_count <= instr_count + CNT_W'(1);
            if (halt_pending || halt_req) begin
              state <= HALT;
              T     <= T_ZERO;
            end else if (!run) begin
              state <= IDLE;
              T     <= T_ZERO;
            end else begin
              state <= FETCH_L;
              T     <= T_FIRST;
            end
          end else if (T[T_W-1]) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            T           <= T_ZERO;
          end else begin
            T <= T << 1;
          end
        end
        HALT: begin
          state <= HALT;
          T     <= T_ZERO;
        end
        default: begin
          state <= IDLE;
          T     <= T_ZERO;
        end
      endcase
    end
  end

  assign fetching     = (state == FETCH_L) || (state == FETCH_H);
  assign fetch_active = fetching && !stall;

  // A stalled fetch keeps the memory selected but blocks the IR load and
  // PC increment, so each completed fetch cycle loads and increments once.
  always_comb begin
    Mem_CS       = ~fetching;
    Mem_WR       = 1'b0;
    IR_Enable    = fetch_active;
    IR_LH        = (state == FETCH_H);
    IR_Funsel    = fetching ? 2'b10 : 2'b00;
    ARF_OutDSel  = PC_SEL;
    ARF_RegSel   = fetch_active ? PC_REGSEL : 4'b1111;
    ARF_FunSel   = fetch_active ? 2'b01 : 2'b00;
    opcode_valid = (state == EXEC);
    busy         = (state != IDLE) && (state != HALT);
    halted       = (state == HALT);
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; a second 4-bit-counter instance
// shares all inputs so counter wrap-around can be exercised in a short run.
module tb_instr_fetch_sequencer;

  logic        Clock;
  logic        Reset;
  logic        run, stall, exec_done, halt_req;
  logic [7:0]  T;
  logic        Mem_CS, Mem_WR, IR_Enable, IR_LH;
  logic [1:0]  IR_Funsel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        opcode_valid, busy, halted, timeout_err;
  logic [15:0] instr_count;

  logic [7:0]  s_T;
  logic        s_Mem_CS, s_Mem_WR, s_IR_Enable, s_IR_LH;
  logic [1:0]  s_IR_Funsel, s_ARF_OutDSel, s_ARF_FunSel;
  logic [3:0]  s_ARF_RegSel;
  logic        s_opcode_valid, s_busy, s_halted, s_timeout_err;
  logic [3:0]  s_instr_count;

  int total = 0;
  int bad   = 0;

  instr_fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .run(run), .stall(stall),
    .exec_done(exec_done), .halt_req(halt_req), .T(T),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
    .IR_Funsel(IR_Funsel), .ARF_OutDSel(ARF_OutDSel), .ARF_RegSel(ARF_RegSel),
    .ARF_FunSel(ARF_FunSel), .opcode_valid(opcode_valid), .busy(busy),
    .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  instr_fetch_sequencer #(.CNT_W(4)) dut_small (
    .Clock(Clock), .Reset(Reset), .run(run), .stall(stall),
    .exec_done(exec_done), .halt_req(halt_req), .T(s_T),
    .Mem_CS(s_Mem_CS), .Mem_WR(s_Mem_WR), .IR_Enable(s_IR_Enable), .IR_LH(s_IR_LH),
    .IR_Funsel(s_IR_Funsel), .ARF_OutDSel(s_ARF_OutDSel), .ARF_RegSel(s_ARF_RegSel),
    .ARF_FunSel(s_ARF_FunSel), .opcode_valid(s_opcode_valid), .busy(s_busy),
    .halted(s_halted), .timeout_err(s_timeout_err), .instr_count(s_instr_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0; run = 1'b0; stall = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    #3;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; run = 1'b0; stall = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
    #1 Reset = 1'b0;
    #1;
    total++; if (T !== 8'h00) begin bad++; $display("[TB] FAIL rst_T: got %h want 00", T); end
    total++; if (Mem_CS !== 1'b1 || Mem_WR !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem: got cs=%b wr=%b want 1 0", Mem_CS, Mem_WR); end
    total++; if ({IR_Enable, IR_LH, IR_Funsel} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_ir: got %b want 0000", {IR_Enable, IR_LH, IR_Funsel}); end
    total++; if ({ARF_RegSel, ARF_FunSel, ARF_OutDSel} !== 8'b1111_00_00) begin bad++; $display("[TB] FAIL rst_arf: got %b want 11110000", {ARF_RegSel, ARF_FunSel, ARF_OutDSel}); end
    total++; if ({opcode_valid, busy, halted, timeout_err} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_flags: got %b want 0000", {opcode_valid, busy, halted, timeout_err}); end
    total++; if (instr_count !== 16'h0000) begin bad++; $display("[TB] FAIL rst_count: got %h want 0000", instr_count); end
    #3 Reset = 1'b1;
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    total++; if (T !== 8'h10 || opcode_valid !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_T4: got T=%h ov=%b want 10 1", T, opcode_valid); end
    Reset = 1'b0;
    #1;
    total++; if (T !== 8'h00 || Mem_CS !== 1'b1 || ARF_RegSel !== 4'b1111) begin bad++; $display("[TB] FAIL async_rst: got T=%h cs=%b rs=%b want 00 1 1111", T, Mem_CS, ARF_RegSel); end
    total++; if (instr_count !== 16'h0000 || busy !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_cnt: got cnt=%h busy=%b want 0000 0", instr_count, busy); end
    Reset = 1'b1;
    tick();
    total++; if (T !== 8'h01 || IR_LH !== 1'b0 || IR_Enable !== 1'b1 || Mem_CS !== 1'b0) begin bad++; $display("[TB] FAIL fetch_l: got T=%h lh=%b en=%b cs=%b want 01 0 1 0", T, IR_LH, IR_Enable, Mem_CS); end
    total++; if (IR_Funsel !== 2'b10 || ARF_RegSel !== 4'b0111 || ARF_FunSel !== 2'b01) begin bad++; $display("[TB] FAIL fetch_l_ctl: got fs=%b rs=%b af=%b want 10 0111 01", IR_Funsel, ARF_RegSel, ARF_FunSel); end
    tick();
    total++; if (T !== 8'h02 || IR_LH !== 1'b1 || IR_Enable !== 1'b1) begin bad++; $display("[TB] FAIL fetch_h: got T=%h lh=%b en=%b want 02 1 1", T, IR_LH, IR_Enable); end
    tick();
    total++; if (T !== 8'h04 || opcode_valid !== 1'b1 || Mem_CS !== 1'b1 || ARF_RegSel !== 4'b1111) begin bad++; $display("[TB] FAIL exec_t2: got T=%h ov=%b cs=%b rs=%b want 04 1 1 1111", T, opcode_valid, Mem_CS, ARF_RegSel); end
  endtask

  task automatic test_three_instr();
    logic [7:0] exp_t [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08,
                               8'h01, 8'h02, 8'h04, 8'h08};
    int pc_incs = 0;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++; if (T !== exp_t[i]) begin bad++; $display("[TB] FAIL seq_T[%0d]: got %h want %h", i, T, exp_t[i]); end
      if (ARF_FunSel == 2'b01 && ARF_RegSel == 4'b0111) pc_incs++;
      exec_done = (i % 4 == 3);
      if (i == 9) run = 1'b0;
    end
    tick();
    exec_done = 1'b0;
    total++; if (T !== 8'h00 || busy !== 1'b0) begin bad++; $display("[TB] FAIL seq_idle: got T=%h busy=%b want 00 0", T, busy); end
    total++; if (instr_count !== 16'd3) begin bad++; $display("[TB] FAIL seq_count: got %0d want 3", instr_count); end
    total++; if (s_instr_count !== 4'd3) begin bad++; $display("[TB] FAIL seq_count_small: got %0d want 3", s_instr_count); end
    total++; if (pc_incs !== 6) begin bad++; $display("[TB] FAIL seq_pc_inc: got %0d want 6", pc_incs); end
  endtask

  task automatic test_stall();
    int hi_loads = 0;
    do_reset();
    run = 1'b1;
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall = 1'b0;
      #1;
      total++; if (T !== 8'h02 || Mem_CS !== 1'b0) begin bad++; $display("[TB] FAIL stall_T[%0d]: got T=%h cs=%b want 02 0", i, T, Mem_CS); end
      if (i < 2) begin
        total++; if (IR_Enable !== 1'b0 || ARF_RegSel !== 4'b1111 || ARF_FunSel !== 2'b00) begin bad++; $display("[TB] FAIL stall_ctl[%0d]: got en=%b rs=%b af=%b want 0 1111 00", i, IR_Enable, ARF_RegSel, ARF_FunSel); end
      end
      if (IR_Enable && IR_LH) hi_loads++;
      tick();
    end
    total++; if (T !== 8'h04 || IR_Enable !== 1'b0) begin bad++; $display("[TB] FAIL stall_exit: got T=%h en=%b want 04 0", T, IR_Enable); end
    total++; if (hi_loads !== 1) begin bad++; $display("[TB] FAIL stall_loads: got %0d want 1", hi_loads); end
    exec_done = 1'b1; run = 1'b0;
    tick();
    exec_done = 1'b0;
    total++; if (instr_count !== 16'd1 || T !== 8'h00) begin bad++; $display("[TB] FAIL stall_done: got cnt=%0d T=%h want 1 00", instr_count, T); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_t [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (T !== exp_t[i]) begin bad++; $display("[TB] FAIL to_T[%0d]: got %h want %h", i, T, exp_t[i]); end
    end
    run = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL to_early: got %b want 0", timeout_err); end
    tick();
    total++; if (timeout_err !== 1'b1 || T !== 8'h00 || busy !== 1'b0) begin bad++; $display("[TB] FAIL to_fire: got err=%b T=%h busy=%b want 1 00 0", timeout_err, T, busy); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("[TB] FAIL to_count: got %0d want 0", instr_count); end
    tick(); tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (T !== 8'h02 || halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_fetch: got T=%h halted=%b want 02 0", T, halted); end
    tick();
    total++; if (T !== 8'h04 || opcode_valid !== 1'b1) begin bad++; $display("[TB] FAIL halt_exec: got T=%h ov=%b want 04 1", T, opcode_valid); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    total++; if (halted !== 1'b1 || T !== 8'h00 || busy !== 1'b0 || instr_count !== 16'd1) begin bad++; $display("[TB] FAIL halt_enter: got h=%b T=%h busy=%b cnt=%0d want 1 00 0 1", halted, T, busy, instr_count); end
    tick(); tick(); tick();
    total++; if (halted !== 1'b1 || T !== 8'h00 || Mem_CS !== 1'b1) begin bad++; $display("[TB] FAIL halt_stay: got h=%b T=%h cs=%b want 1 00 1", halted, T, Mem_CS); end
    do_reset();
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_clear: got %b want 0", halted); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (halted !== 1'b1 || T !== 8'h00) begin bad++; $display("[TB] FAIL halt_idle: got h=%b T=%h want 1 00", halted, T); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run = 1'b1; exec_done = 1'b1;
    tick();
    total++; if (T !== 8'h01 || instr_count !== 16'd0) begin bad++; $display("[TB] FAIL b2b_first: got T=%h cnt=%0d want 01 0", T, instr_count); end
    for (int i = 1; i < 48; i++) tick();
    total++; if (T !== 8'h04 || s_instr_count !== 4'hF || instr_count !== 16'd15) begin bad++; $display("[TB] FAIL b2b_pre_wrap: got T=%h s=%h cnt=%0d want 04 f 15", T, s_instr_count, instr_count); end
    tick();
    total++; if (s_instr_count !== 4'h0 || instr_count !== 16'd16 || T !== 8'h01) begin bad++; $display("[TB] FAIL b2b_wrap: got s=%h cnt=%0d T=%h want 0 16 01", s_instr_count, instr_count, T); end
    run = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_three_instr();
    test_stall();
    test_timeout();
    test_halt();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
